// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: WIDTH-bit adder computing CHUNK bits per clock; define SERIAL_ADDER_SUBTRACT_EN to add a sub port
module serial_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int N  = WIDTH / CHUNK;
    localparam int SW = $clog2(N + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   slice;
    int               base;

    // Subtraction folds into the add path as a + ~b + 1, fixed at capture time
`ifdef SERIAL_ADDER_SUBTRACT_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub | carryin;
`else
    assign b_in = b;
    assign c_in = carryin;
`endif

    assign base  = int'(step_q) * CHUNK;
    assign a_ch  = a_q[base +: CHUNK];
    assign b_ch  = b_q[base +: CHUNK];
    assign slice = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_q};

    assign sum      = sum_q;
    assign carryout = cout_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Next state: accept in IDLE, one slice per edge in RUN, publish all results together on the last slice
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                a_d     = a;
                b_d     = b_in;
                c_d     = c_in;
                step_d  = '0;
                busy_d  = 1'b1;
                state_d = RUN;
            end
        end else begin
            res_d[base +: CHUNK] = slice[CHUNK-1:0];
            c_d    = slice[CHUNK];
            step_d = step_q + SW'(1);
            if (step_q == SW'(N - 1)) begin
                sum_d   = res_d;
                cout_d  = slice[CHUNK];
                ovf_d   = slice[CHUNK] ^ slice[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // State and datapath registers; reset aborts any operation and clears the visible result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: directed and random checks of serial_chunk_adder for CHUNK = 4, 1 and 32
module tb_serial_chunk_adder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  st = '0;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic [31:0] sm [3];
    logic [2:0]  co, ov, bz, dn;
    int          checks = 0, fails = 0;
    int          lat [3] = '{9, 33, 2};

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : u
            localparam int CH = (g == 0) ? 4 : (g == 1) ? 1 : 32;
            serial_chunk_adder #(.WIDTH(32), .CHUNK(CH)) dut (
                .clk(clk),
                .reset(reset),
                .start(st[g]),
                .a(a),
                .b(b),
                .carryin(cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
                .sub(1'b0),
`endif
                .sum(sm[g]),
                .carryout(co[g]),
                .overflow(ov[g]),
                .busy(bz[g]),
                .done(dn[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete operation on instance sel, compared against plain 33-bit arithmetic
    task automatic op(input int sel, input logic [31:0] ia, input logic [31:0] ib, input logic ic);
        int n;
        logic [32:0] e;
        logic eo;
        @(negedge clk);
        a = ia; b = ib; cin = ic; st[sel] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                st = '0; a = $urandom; b = $urandom; cin = 1'($urandom);
                chk("busy_run", 64'(bz[sel]), 64'(lat[sel] > 2 || dn[sel] == 1'b0));
            end
        end while (!dn[sel] && n < 200);
        e  = {1'b0, ia} + {1'b0, ib} + 33'(ic);
        eo = (ia[31] == ib[31]) && (e[31] != ia[31]);
        chk("latency", 64'(n), 64'(lat[sel]));
        chk("sum", 64'(sm[sel]), 64'(e[31:0]));
        chk("carryout", 64'(co[sel]), 64'(e[32]));
        chk("overflow", 64'(ov[sel]), 64'(eo));
        chk("busy_done", 64'(bz[sel]), 64'(0));
        @(negedge clk);
        chk("done_pulse", 64'(dn[sel]), 64'(0));
        chk("sum_hold", 64'(sm[sel]), 64'(e[31:0]));
    endtask

    initial begin
        int cnt, k1, k2;
        logic [31:0] got;
        // Reset held with start asserted: nothing accepted, everything zero
        st = 3'b111; a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sum", 64'(sm[0]), 64'(0));
        chk("rst_flags", 64'({co, ov, dn}), 64'(0));
        chk("rst_busy", 64'(bz), 64'(0));
        reset = 1'b0; st = '0;
        @(negedge clk);
        chk("idle_busy", 64'(bz), 64'(0));

        op(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        op(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        op(0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        op(1, 32'h7FFF_FFFF, 32'h1, 1'b0);
        op(2, 32'hFFFF_FFFF, 32'h1, 1'b0);

        // Second start during RUN is dropped
        @(negedge clk);
        a = 32'd5; b = 32'd3; cin = 1'b0; st[0] = 1'b1;
        cnt = 0; got = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) st[0] = 1'b0;
            if (k == 3) begin a = 32'd100; b = 32'd100; st[0] = 1'b1; end
            if (k == 4) st[0] = 1'b0;
            if (dn[0]) begin cnt++; got = sm[0]; end
        end
        chk("drop_count", 64'(cnt), 64'(1));
        chk("drop_sum", 64'(got), 64'(8));

        // Reset four cycles into RUN aborts asynchronously
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", 64'(bz[0]), 64'(1));
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(bz[0]), 64'(0));
        chk("abort_sum", 64'(sm[0]), 64'(0));
        chk("abort_flags", 64'({co[0], ov[0], dn[0]}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (dn[0]) cnt++;
        end
        chk("abort_no_done", 64'(cnt), 64'(0));
        op(0, 32'd1, 32'd1, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        a = 32'd1; b = 32'd2; cin = 1'b0; st[0] = 1'b1;
        cnt = 0; k1 = 0; k2 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin a = 32'd3; b = 32'd4; cin = 1'b1; end
            if (k == 10) st[0] = 1'b0;
            if (dn[0]) begin
                cnt++;
                if (cnt == 1) begin k1 = k; chk("b2b_sum1", 64'(sm[0]), 64'(3)); end
                else begin k2 = k; chk("b2b_sum2", 64'(sm[0]), 64'(8)); end
            end
        end
        chk("b2b_count", 64'(cnt), 64'(2));
        chk("b2b_first", 64'(k1), 64'(9));
        chk("b2b_gap", 64'(k2 - k1), 64'(9));

        // Random vectors on every chunk size
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 500; i++)
                op(s, $urandom, $urandom, 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
